// File: rtl/ps2_key_matrix.sv
// PS/2 scan-code decoder that maintains a 16-key hex keypad matrix.
// It handles set-2 make, break and extended prefixes and pulses on each key state change.
module ps2_key_matrix #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_ready,
    input  logic [7:0]  ps2_data,
    input  logic        clear,
    output logic [15:0] key_matrix,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic        key_down
);

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   accept_c;
    logic                   map_hit_c;
    logic [3:0]             map_key_c;

    // Bring the asynchronous strobe into clk and keep the previous level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ps2_ready};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign accept_c = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Map a scan code to its hex keypad position.
    always_comb begin
        map_hit_c = 1'b1;
        map_key_c = 4'h0;
        case (ps2_data)
            8'h16: map_key_c = 4'h1;
            8'h1E: map_key_c = 4'h2;
            8'h26: map_key_c = 4'h3;
            8'h25: map_key_c = 4'hC;
            8'h15: map_key_c = 4'h4;
            8'h1D: map_key_c = 4'h5;
            8'h24: map_key_c = 4'h6;
            8'h2D: map_key_c = 4'hD;
            8'h1C: map_key_c = 4'h7;
            8'h1B: map_key_c = 4'h8;
            8'h23: map_key_c = 4'h9;
            8'h2B: map_key_c = 4'hE;
            8'h1A: map_key_c = 4'hA;
            8'h22: map_key_c = 4'h0;
            8'h21: map_key_c = 4'hB;
            8'h2A: map_key_c = 4'hF;
            default: map_hit_c = 1'b0;
        endcase
    end

    // Prefix state machine; events fire only when a matrix bit actually changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            key_matrix <= '0;
            key_event  <= 1'b0;
            key_code   <= '0;
            key_down   <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                key_matrix <= '0;
            end else if (accept_c) begin
                case (state)
                    IDLE: begin
                        if (ps2_data == CODE_BRK) begin
                            state <= BRK;
                        end else if (ps2_data == CODE_EXT) begin
                            state <= EXT;
                        end else if (map_hit_c && !key_matrix[map_key_c]) begin
                            key_matrix[map_key_c] <= 1'b1;
                            key_event             <= 1'b1;
                            key_code              <= map_key_c;
                            key_down              <= 1'b1;
                        end
                    end
                    BRK: begin
                        state <= IDLE;
                        if (map_hit_c && key_matrix[map_key_c]) begin
                            key_matrix[map_key_c] <= 1'b0;
                            key_event             <= 1'b1;
                            key_code              <= map_key_c;
                            key_down              <= 1'b0;
                        end
                    end
                    EXT: begin
                        state <= (ps2_data == CODE_BRK) ? EXT_BRK : IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix: latency, repeat suppression, prefixes, clear and reset behaviour.
module tb_ps2_key_matrix;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_ready = 1'b0;
    logic [7:0]  ps2_data = 8'h00;
    logic        clear = 1'b0;
    logic [15:0] key_matrix;
    logic        key_event;
    logic [3:0]  key_code;
    logic        key_down;

    int checks = 0;
    int errors = 0;
    int ev_cnt = 0;
    int ev_base;

    ps2_key_matrix #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_ready  (ps2_ready),
        .ps2_data   (ps2_data),
        .clear      (clear),
        .key_matrix (key_matrix),
        .key_event  (key_event),
        .key_code   (key_code),
        .key_down   (key_down)
    );

    always #5 clk = ~clk;

    // The pulse is high for one full cycle, so each falling edge sees it exactly once per cycle.
    always @(negedge clk) if (key_event === 1'b1) ev_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ps2_data  = b;
        ps2_ready = 1'b1;
        repeat (4) @(negedge clk);
        ps2_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_matrix", 32'(key_matrix), 32'h0);
        check("rst_event",  32'(key_event),  32'h0);
        check("rst_code",   32'(key_code),   32'h0);
        check("rst_down",   32'(key_down),   32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Single press with exact latency
        ev_base = ev_cnt;
        @(negedge clk);
        ps2_data  = 8'h1E;
        ps2_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("lat_edge2_matrix", 32'(key_matrix), 32'h0);
        @(posedge clk);
        #1;
        check("lat_edge3_matrix", 32'(key_matrix), 32'h0004);
        check("lat_edge3_event",  32'(key_event),  32'h1);
        check("lat_edge3_code",   32'(key_code),   32'h2);
        check("lat_edge3_down",   32'(key_down),   32'h1);
        @(negedge clk);
        ps2_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("press_one_event", 32'(ev_cnt - ev_base), 32'd1);

        // Typematic repeats then release: two events total
        do_clear();
        check("clear_matrix", 32'(key_matrix), 32'h0);
        ev_base = ev_cnt;
        send_byte(8'h1E);
        send_byte(8'h1E);
        send_byte(8'h1E);
        send_byte(8'hF0);
        send_byte(8'h1E);
        check("repeat_events", 32'(ev_cnt - ev_base), 32'd2);
        check("repeat_matrix", 32'(key_matrix),       32'h0);
        check("release_down",  32'(key_down),         32'h0);
        check("release_code",  32'(key_code),         32'h2);

        // Multiple keys held; extended break ignored
        ev_base = ev_cnt;
        send_byte(8'h16);
        send_byte(8'h2A);
        check("multi_matrix", 32'(key_matrix),       32'h8002);
        check("multi_events", 32'(ev_cnt - ev_base), 32'd2);
        ev_base = ev_cnt;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h16);
        check("ext_matrix", 32'(key_matrix),       32'h8002);
        check("ext_events", 32'(ev_cnt - ev_base), 32'd0);
        check("ext_code",   32'(key_code),         32'hF);

        // Unmapped codes, break of an unheld key, break prefix back to IDLE
        do_clear();
        ev_base = ev_cnt;
        send_byte(8'h76);
        send_byte(8'hF0);
        send_byte(8'h16);
        send_byte(8'hF0);
        send_byte(8'h76);
        send_byte(8'h26);
        check("unmapped_matrix", 32'(key_matrix),       32'h0008);
        check("unmapped_events", 32'(ev_cnt - ev_base), 32'd1);
        check("unmapped_code",   32'(key_code),         32'h3);

        // Reset discards a pending break prefix
        do_clear();
        send_byte(8'hF0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h16);
        check("rstpfx_matrix", 32'(key_matrix), 32'h0002);
        check("rstpfx_down",   32'(key_down),   32'h1);

        // Clear in the acceptance cycle wins over the byte
        do_clear();
        send_byte(8'h1D);
        check("hold5_matrix", 32'(key_matrix), 32'h0020);
        ev_base = ev_cnt;
        @(negedge clk);
        ps2_data  = 8'h25;
        ps2_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("clracc_matrix", 32'(key_matrix), 32'h0);
        check("clracc_event",  32'(key_event),  32'h0);
        @(negedge clk);
        clear = 1'b0;
        repeat (3) @(negedge clk);
        ps2_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("clracc_events", 32'(ev_cnt - ev_base), 32'd0);
        send_byte(8'h25);
        check("clracc_next", 32'(key_matrix), 32'h1000);

        // Long strobe yields a single acceptance
        do_clear();
        ev_base = ev_cnt;
        @(negedge clk);
        ps2_data  = 8'h1D;
        ps2_ready = 1'b1;
        repeat (1000) @(negedge clk);
        check("long_matrix", 32'(key_matrix),       32'h0020);
        check("long_events", 32'(ev_cnt - ev_base), 32'd1);
        ps2_ready = 1'b0;
        repeat (4) @(negedge clk);

        // Strobe already high when reset deasserts
        @(negedge clk);
        reset     = 1'b1;
        ps2_data  = 8'h16;
        ps2_ready = 1'b1;
        @(negedge clk);
        check("rsthi_matrix0", 32'(key_matrix), 32'h0);
        ev_base = ev_cnt;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rsthi_matrix", 32'(key_matrix), 32'h0002);
        check("rsthi_event",  32'(key_event),  32'h1);
        repeat (10) @(negedge clk);
        check("rsthi_events", 32'(ev_cnt - ev_base), 32'd1);
        ps2_ready = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
